// File: rtl/video_wb_arbiter.sv
// -----------------------------------------------------------------------------
// video_wb_arbiter
//
// Purpose:
//   Shares the single Wishbone RAM master port between two video masters:
//   m0 = video_in frame writer, m1 = video_out frame reader.
//   - Arbitration is round-robin, decided once per bus cycle (CYC).
//   - LOCK lets the current owner keep the grant across gaps in CYC.
//   - The block sits between the video DMA engines and the RAM/interconnect
//     slave port.
//
// Optional feature (macro WB_ARB_WATCHDOG_EN):
//   When defined, a stall watchdog aborts an owner whose strobe goes
//   TIMEOUT_CYCLES cycles without an ACK. It pulses m_ERR_O[owner], masks the
//   slave CYC/STB for that cycle and returns the arbiter to IDLE.
//   When undefined, m_ERR_O is tied low and a hung slave holds the owner
//   forever.
//
// Parameters:
//   ADR_W          address width
//   DAT_W          data width
//   TIMEOUT_CYCLES watchdog stall limit (watchdog build only, clamped to 8 bits)
//
// Ports:
//   clk, nRST                 clock (rising edge) and async active-low reset
//   m_CYC_I/STB_I/LOCK_I/WE_I per-master control, bit i = master i
//   m_SEL_I                   per-master byte select, [4i+3:4i]
//   m_ADR_I, m_DAT_I          per-master address / write data, [W*i +: W]
//   m_ACK_O, m_ERR_O          per-master ACK / watchdog abort, owner only
//   m_DAT_O                   read data broadcast (qualified by m_ACK_O)
//   p_wb_*_O                  slave-side request signals of the current owner
//   p_wb_DAT_I, p_wb_ACK_I    slave read data and acknowledge
//   grant                     one-hot current owner, 2'b00 when idle
// -----------------------------------------------------------------------------
module video_wb_arbiter #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
`ifdef WB_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic [1:0]         m_CYC_I,
    input  logic [1:0]         m_STB_I,
    input  logic [1:0]         m_LOCK_I,
    input  logic [1:0]         m_WE_I,
    input  logic [7:0]         m_SEL_I,
    input  logic [2*ADR_W-1:0] m_ADR_I,
    input  logic [2*DAT_W-1:0] m_DAT_I,
    output logic [1:0]         m_ACK_O,
    output logic [1:0]         m_ERR_O,
    output logic [DAT_W-1:0]   m_DAT_O,
    output logic               p_wb_CYC_O,
    output logic               p_wb_STB_O,
    output logic               p_wb_LOCK_O,
    output logic               p_wb_WE_O,
    output logic [3:0]         p_wb_SEL_O,
    output logic [ADR_W-1:0]   p_wb_ADR_O,
    output logic [DAT_W-1:0]   p_wb_DAT_O,
    input  logic [DAT_W-1:0]   p_wb_DAT_I,
    input  logic               p_wb_ACK_I,
    output logic [1:0]         grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // index of the most recent owner

    logic   own_active;         // some master currently owns the slave port
    logic   owner_idx;          // which master, valid when own_active
    logic   timeout;            // watchdog abort this cycle

    // Per-master views of the packed input buses
    logic [3:0]       sel_arr [2];
    logic [ADR_W-1:0] adr_arr [2];
    logic [DAT_W-1:0] dat_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign sel_arr[gi] = m_SEL_I[4*gi +: 4];
            assign adr_arr[gi] = m_ADR_I[ADR_W*gi +: ADR_W];
            assign dat_arr[gi] = m_DAT_I[DAT_W*gi +: DAT_W];
        end
    endgenerate

    assign own_active = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign owner_idx  = (state_q == ST_OWN1);

    // Read data is broadcast; only the owner sees an ACK qualifying it.
    assign m_DAT_O = p_wb_DAT_I;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;    // m0 wins the first tie after reset
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m_CYC_I == 2'b11) begin
                    // Tie: the master that did not own the bus last wins.
                    if (last_q) begin
                        state_d = ST_OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_OWN1;
                        last_d  = 1'b1;
                    end
                end else if (m_CYC_I[0]) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (m_CYC_I[1]) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // Always pass through IDLE between owners; a watchdog abort
                // releases even a locked owner.
                if (timeout || (!m_CYC_I[owner_idx] && !m_LOCK_I[owner_idx])) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output mux: the owner's request goes straight through to the slave
    // -------------------------------------------------------------------------
    always_comb begin
        p_wb_CYC_O  = 1'b0;
        p_wb_STB_O  = 1'b0;
        p_wb_LOCK_O = 1'b0;
        p_wb_WE_O   = 1'b0;
        p_wb_SEL_O  = 4'h0;
        p_wb_ADR_O  = '0;
        p_wb_DAT_O  = '0;
        m_ACK_O     = 2'b00;
        m_ERR_O     = 2'b00;
        grant       = 2'b00;
        if (own_active) begin
            // A locked owner with CYC low keeps the grant but shows CYC=0.
            p_wb_CYC_O           = m_CYC_I[owner_idx] & ~timeout;
            p_wb_STB_O           = m_STB_I[owner_idx] & ~timeout;
            p_wb_LOCK_O          = m_LOCK_I[owner_idx];
            p_wb_WE_O            = m_WE_I[owner_idx];
            p_wb_SEL_O           = sel_arr[owner_idx];
            p_wb_ADR_O           = adr_arr[owner_idx];
            p_wb_DAT_O           = dat_arr[owner_idx];
            m_ACK_O[owner_idx]   = p_wb_ACK_I;
            m_ERR_O[owner_idx]   = timeout;
            grant[owner_idx]     = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Stall watchdog
    // -------------------------------------------------------------------------
`ifdef WB_ARB_WATCHDOG_EN
    localparam logic [7:0] TMO_C = (TIMEOUT_CYCLES > 255) ? 8'd255 : 8'(TIMEOUT_CYCLES);

    logic [7:0] wdog_q, wdog_d;
    logic       stalled;

    // Uses the raw owner strobe: the masked p_wb_STB_O depends on timeout.
    assign stalled = own_active & m_STB_I[owner_idx] & ~p_wb_ACK_I;
    // Fires on the cycle whose stall brings the count up to the limit.
    assign timeout = stalled && (({1'b0, wdog_q} + 9'd1) == {1'b0, TMO_C});

    always_comb begin
        wdog_d = wdog_q;
        if (!own_active || p_wb_ACK_I || timeout) begin
            wdog_d = 8'd0;
        end else if (stalled) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
